object_slot_scheduler: RTL and testbench
========================================

// Module: object_slot_scheduler
// PURPOSE
//   Owns the pool of falling-object slots for the parachute game. Queues lane spawn pulses
//   (obj0..obj3) from the game FSM and allocates them to free slots. Advances every active
//   slot's Y on each frame tick and retires slots on catch or on reaching the bottom.
//   Sits between the game FSM and the sprite/collision logic.
// PARAMETERS
//   NUM_SLOTS  4    concurrent falling objects; must be >= 1
//   Y_WIDTH    10   bits of a slot Y coordinate
//   Y_START    0    Y loaded into a newly allocated slot
//   Y_BOTTOM   479  last on-screen row; an object moving past this row is a miss
//   FALL_STEP  2    pixels added per frame tick
// PORTS
//   Clk          in   1                    system clock
//   Reset        in   1                    synchronous, active-high
//   clear        in   1                    synchronous flush (game_reset / menu); same effect as Reset
//   spawn_req    in   4                    lane spawn pulses, bit i = obj i, 1 cycle each
//   frame_tick   in   1                    1-cycle pulse per video frame
//   catch_valid  in   1                    collision logic reports a catch
//   catch_slot   in   $clog2(NUM_SLOTS)    slot index that was caught
//   slot_active  out  NUM_SLOTS            slot occupied
//   slot_lane    out  2*NUM_SLOTS          lane of slot k at bits [2k+1:2k]
//   slot_y       out  Y_WIDTH*NUM_SLOTS    Y of slot k at bits [Y_WIDTH*k +: Y_WIDTH]
//   score_inc    out  1                    1-cycle pulse per accepted catch
//   miss         out  1                    1-cycle pulse per object reaching the bottom
//   overflow     out  1                    sticky: a spawn was dropped
// BEHAVIOUR
//   Reset/clear: all outputs 0; pending mask 0; FSM in IDLE; tick_pending 0; RR pointer 0.
//   Reset and clear override every other input in the same cycle.
//   Pending mask (4 bits, registered)
//   - spawn_req[i] sets pend[i] at the next edge.
//   - If pend[i] is already 1 and is not being cleared that cycle, the request is dropped
//     and overflow is set (held until Reset/clear).
//   FSM states: IDLE, ALLOC, UPDATE
//   - IDLE:
//     - frame_tick or tick_pending -> UPDATE, with index 0.
//     - else if pend != 0 and a free slot exists -> ALLOC.
//   - ALLOC (1 cycle):
//     - rr_arbiter grants one pending lane; the lowest-index free slot is loaded with
//       lane, Y_START, active=1.
//     - The granted pend bit is cleared; the RR pointer advances past the granted lane.
//     - Next state is IDLE.
//   - UPDATE (NUM_SLOTS cycles, index k = 0..NUM_SLOTS-1):
//     - If slot k is active: when y_k + FALL_STEP > Y_BOTTOM (compare at Y_WIDTH+1 bits,
//       no wrap), free the slot and pulse miss next cycle; otherwise
//       y_k <= y_k + FALL_STEP.
//     - After k = NUM_SLOTS-1, return to IDLE.
//     - No allocation happens while in UPDATE.
//   - Spawn latency: spawn_req at cycle t, pend at t+1, slot_active at t+3 at the earliest
//     (IDLE at t+1, ALLOC at t+2).
//   - All free slots taken: pend bits are held and retried whenever the FSM is in IDLE.
//   frame_tick outside IDLE sets tick_pending (1 deep; extra ticks are silently dropped).
//   tick_pending clears when UPDATE is entered.
//   Catch
//   - catch_valid on an active slot: the slot is freed at the next edge and score_inc
//     pulses in that same cycle. This is accepted in any state.
//   - catch_valid on an inactive slot is ignored.
//   - A catch on slot k in the same cycle UPDATE processes slot k: the catch wins
//     (score_inc, no miss, Y not written).
//   - A catch on a slot in the same cycle ALLOC would pick it: ALLOC skips that slot
//     (the freed slot is not visible until the next cycle).
//   score_inc and miss can pulse in the same cycle when they concern different slots.
//   A freed slot keeps its lane and Y values; consumers must gate on slot_active.
// STRUCTURE
//   parachute_pkg: NUM_LANES=4, lane_t (logic [1:0]), sched_state_t enum {IDLE,ALLOC,UPDATE}.
//   Sub-module rr_arbiter: 4-way round-robin, combinational grant plus registered pointer;
//   inputs req[3:0], advance; output grant one-hot.
//   Free-slot search is a priority encoder inside this module.
// TESTING
//   1) Reset, then spawn_req=4'b0001 -> slot 0 active, lane 0, y=0 at t+3; score_inc=miss=0.
//   2) spawn_req=4'b1111 in one cycle -> slots 0..3 get lanes 0,1,2,3 on 4 successive
//      ALLOC cycles; overflow=0.
//   3) One slot, 240 frame ticks (Y_BOTTOM=479, step 2) -> y=478 after tick 239; tick 240
//      gives a single miss pulse and slot_active=0.
//   4) catch_valid for slot 2 in the cycle UPDATE processes slot 2 with y=478 ->
//      score_inc=1, miss=0, slot freed.
//   5) All 4 slots busy, spawn lane 1 twice -> first request held in pend[1], second sets
//      overflow=1; a catch frees a slot -> lane 1 allocated.
//   6) clear asserted mid-UPDATE -> next cycle all slot_active=0, pend=0, FSM IDLE,
//      overflow=0.

Source files
------------

// File: rtl/object_slot_scheduler_pkg.sv
// rtl/object_slot_scheduler_pkg.sv - shared types for the falling-object slot scheduler
// Purpose : lane and FSM state types, plus a one-hot to lane index helper.
// Ports   : none (package).
package parachute_pkg;

   localparam int NUM_LANES = 4;

   typedef logic [1:0] lane_t;

   typedef enum logic [1:0] {
      IDLE,
      ALLOC,
      UPDATE
   } sched_state_t;

   function automatic lane_t onehot_to_lane(input logic [NUM_LANES-1:0] oh);
      onehot_to_lane = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (oh[i]) onehot_to_lane = lane_t'(i);
      end
   endfunction

endpackage

// File: rtl/object_slot_scheduler_if.sv
// rtl/object_slot_scheduler_if.sv - game FSM / collision side bus of the slot scheduler
// Purpose : groups spawn, frame tick and catch inputs with the slot state outputs.
// Ports   : master = game/collision side, slave = scheduler.
//           clear, spawn_req[3:0], frame_tick, catch_valid, catch_slot  (master -> slave)
//           slot_active, slot_lane, slot_y, score_inc, miss, overflow   (slave -> master)
interface object_slot_scheduler_if #(
   parameter int NUM_SLOTS = 4,
   parameter int Y_WIDTH   = 10
);
   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   logic                         clear;
   logic [3:0]                   spawn_req;
   logic                         frame_tick;
   logic                         catch_valid;
   logic [IDX_W-1:0]             catch_slot;
   logic [NUM_SLOTS-1:0]         slot_active;
   logic [2*NUM_SLOTS-1:0]       slot_lane;
   logic [Y_WIDTH*NUM_SLOTS-1:0] slot_y;
   logic                         score_inc;
   logic                         miss;
   logic                         overflow;

   modport master (
      output clear, spawn_req, frame_tick, catch_valid, catch_slot,
      input  slot_active, slot_lane, slot_y, score_inc, miss, overflow
   );

   modport slave (
      input  clear, spawn_req, frame_tick, catch_valid, catch_slot,
      output slot_active, slot_lane, slot_y, score_inc, miss, overflow
   );
endinterface

// File: rtl/object_slot_scheduler_rr_arbiter.sv
// rtl/object_slot_scheduler_rr_arbiter.sv - 4-way round-robin lane arbiter
// Purpose : combinational one-hot grant searching upward from a registered pointer.
// Ports   : Clk, Reset (sync, active-high), req[3:0], advance (grant consumed),
//           grant[3:0] one-hot (zero when no request).
module rr_arbiter
   import parachute_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [NUM_LANES-1:0] req,
   input  logic                 advance,
   output logic [NUM_LANES-1:0] grant
);

   lane_t ptr;
   lane_t cand;
   logic  found;

   // lane_t wraps naturally, so ptr + o walks the lanes circularly.
   always_comb begin
      grant = '0;
      found = 1'b0;
      cand  = ptr;
      for (int o = 0; o < NUM_LANES; o++) begin
         cand = ptr + lane_t'(o);
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= onehot_to_lane(grant) + lane_t'(1);
      end
   end

endmodule

// File: rtl/object_slot_scheduler.sv
// rtl/object_slot_scheduler.sv - falling-object slot pool: spawn queueing, fall update, retire
// Purpose : queues lane spawn pulses, allocates free slots, advances Y per frame, retires
//           slots on catch or on passing the bottom row.
// Ports   : Clk, Reset (sync, active-high), bus (slave modport of object_slot_scheduler_if).
module object_slot_scheduler
   import parachute_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int Y_WIDTH   = 10,
   parameter int Y_START   = 0,
   parameter int Y_BOTTOM  = 479,
   parameter int FALL_STEP = 2
) (
   input logic                   Clk,
   input logic                   Reset,
   object_slot_scheduler_if.slave bus
);

   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [Y_WIDTH:0]   STEP_X   = (Y_WIDTH+1)'(FALL_STEP);
   localparam logic [Y_WIDTH:0]   BOTTOM_X = (Y_WIDTH+1)'(Y_BOTTOM);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SLOTS-1);

   sched_state_t         state;
   logic [IDX_W-1:0]     idx;
   logic [NUM_LANES-1:0] pend;
   logic                 tick_pending;
   logic [NUM_SLOTS-1:0] active;
   lane_t                lane [NUM_SLOTS];
   logic [Y_WIDTH-1:0]   y    [NUM_SLOTS];
   logic                 score_inc_r;
   logic                 miss_r;
   logic                 overflow_r;

   logic                 flush;
   logic [NUM_LANES-1:0] grant;
   logic [NUM_LANES-1:0] pend_clr;
   logic                 alloc_fire;
   logic                 free_any;
   logic [IDX_W-1:0]     free_idx;
   logic                 catch_hit;
   logic [Y_WIDTH:0]     y_next;

   assign flush = Reset | bus.clear;

   rr_arbiter u_arb (
      .Clk     (Clk),
      .Reset   (flush),
      .req     (pend),
      .advance (alloc_fire),
      .grant   (grant)
   );

   // Lowest-index free slot; searched from the top so the lowest hit wins.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int k = NUM_SLOTS-1; k >= 0; k--) begin
         if (!active[k]) begin
            free_any = 1'b1;
            free_idx = IDX_W'(k);
         end
      end
   end

   assign alloc_fire = (state == ALLOC) && free_any && (|grant);
   assign pend_clr   = alloc_fire ? grant : '0;
   assign catch_hit  = bus.catch_valid && (32'(bus.catch_slot) < NUM_SLOTS)
                       && active[bus.catch_slot];
   // One extra bit so the bottom compare cannot wrap.
   assign y_next     = {1'b0, y[idx]} + STEP_X;

   always_ff @(posedge Clk) begin
      if (flush) begin
         state        <= IDLE;
         idx          <= '0;
         pend         <= '0;
         tick_pending <= 1'b0;
         active       <= '0;
         score_inc_r  <= 1'b0;
         miss_r       <= 1'b0;
         overflow_r   <= 1'b0;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            lane[k] <= '0;
            y[k]    <= '0;
         end
      end else begin
         score_inc_r <= 1'b0;
         miss_r      <= 1'b0;

         pend <= (pend & ~pend_clr) | bus.spawn_req;
         if (|(bus.spawn_req & pend & ~pend_clr)) overflow_r <= 1'b1;

         if (bus.frame_tick && state != IDLE) tick_pending <= 1'b1;

         case (state)
            IDLE: begin
               if (bus.frame_tick || tick_pending) begin
                  state        <= UPDATE;
                  idx          <= '0;
                  tick_pending <= 1'b0;
               end else if ((|pend) && free_any) begin
                  state <= ALLOC;
               end
            end
            ALLOC: begin
               // Uses the registered active mask, so a slot freed by a catch this
               // same cycle is not yet a candidate.
               if (alloc_fire) begin
                  active[free_idx] <= 1'b1;
                  lane[free_idx]   <= onehot_to_lane(grant);
                  y[free_idx]      <= Y_WIDTH'(Y_START);
               end
               state <= IDLE;
            end
            UPDATE: begin
               // A catch on the slot under update takes priority over the fall step.
               if (active[idx] && !(catch_hit && bus.catch_slot == idx)) begin
                  if (y_next > BOTTOM_X) begin
                     active[idx] <= 1'b0;
                     miss_r      <= 1'b1;
                  end else begin
                     y[idx] <= y_next[Y_WIDTH-1:0];
                  end
               end
               if (idx == LAST_IDX) state <= IDLE;
               else                 idx   <= idx + 1'b1;
            end
            default: state <= IDLE;
         endcase

         if (catch_hit) begin
            active[bus.catch_slot] <= 1'b0;
            score_inc_r            <= 1'b1;
         end
      end
   end

   assign bus.slot_active = active;
   assign bus.score_inc   = score_inc_r;
   assign bus.miss        = miss_r;
   assign bus.overflow    = overflow_r;

   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_out
      assign bus.slot_lane[2*k +: 2]             = lane[k];
      assign bus.slot_y[Y_WIDTH*k +: Y_WIDTH]    = y[k];
   end

endmodule

// File: tb/tb_object_slot_scheduler.sv
// tb/tb_object_slot_scheduler.sv - self-checking bench for object_slot_scheduler
module tb_object_slot_scheduler;

   localparam int NS        = 4;
   localparam int YW        = 10;
   localparam int Y_START   = 0;
   localparam int Y_BOTTOM  = 479;
   localparam int FALL_STEP = 2;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   object_slot_scheduler_if #(.NUM_SLOTS(NS), .Y_WIDTH(YW)) bus ();

   object_slot_scheduler #(
      .NUM_SLOTS(NS), .Y_WIDTH(YW), .Y_START(Y_START),
      .Y_BOTTOM(Y_BOTTOM), .FALL_STEP(FALL_STEP)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase is tracked as "update slot number" (-1 = not updating) plus an alloc flag.
   bit m_act  [NS];
   int m_lane [NS];
   int m_y    [NS];
   bit m_pend [4];
   int m_rr;
   bit m_tickp;
   int m_upd;
   bit m_alloc;
   bit m_score, m_miss, m_ovf;

   bit old_act [NS];
   bit was_idle, any_free, any_pend;
   int g, slot, cs, k, l;

   always @(posedge Clk) begin
      if (Reset || bus.clear) begin
         for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_lane[i] = 0; m_y[i] = 0;
         end
         for (int i = 0; i < 4; i++) m_pend[i] = 0;
         m_rr = 0; m_tickp = 0; m_upd = -1; m_alloc = 0;
         m_score = 0; m_miss = 0; m_ovf = 0;
      end else begin
         old_act  = m_act;
         was_idle = (m_upd < 0) && !m_alloc;
         m_score  = 0;
         m_miss   = 0;
         cs       = int'(bus.catch_slot);
         g        = -1;
         if (m_alloc) begin
            slot = -1;
            for (int i = 0; i < NS; i++) if (!old_act[i] && slot < 0) slot = i;
            for (int o = 0; o < 4; o++) begin
               l = (m_rr + o) % 4;
               if (g < 0 && m_pend[l]) g = l;
            end
            if (slot >= 0 && g >= 0) begin
               m_act[slot]  = 1;
               m_lane[slot] = g;
               m_y[slot]    = Y_START;
               m_rr         = (g + 1) % 4;
            end else begin
               g = -1;
            end
            m_alloc = 0;
         end else if (m_upd >= 0) begin
            k = m_upd;
            if (old_act[k] && !(bus.catch_valid && cs == k)) begin
               if (m_y[k] + FALL_STEP > Y_BOTTOM) begin
                  m_act[k] = 0;
                  m_miss   = 1;
               end else begin
                  m_y[k] = m_y[k] + FALL_STEP;
               end
            end
            m_upd = (k == NS-1) ? -1 : k + 1;
         end else begin
            any_free = 0;
            any_pend = 0;
            for (int i = 0; i < NS; i++) if (!old_act[i]) any_free = 1;
            for (int i = 0; i < 4; i++) if (m_pend[i]) any_pend = 1;
            if (bus.frame_tick || m_tickp) begin
               m_upd   = 0;
               m_tickp = 0;
            end else if (any_pend && any_free) begin
               m_alloc = 1;
            end
         end
         if (!was_idle && bus.frame_tick) m_tickp = 1;
         for (int i = 0; i < 4; i++) begin
            if (bus.spawn_req[i] && m_pend[i] && g != i) m_ovf = 1;
            m_pend[i] = (m_pend[i] && g != i) || bus.spawn_req[i];
         end
         if (bus.catch_valid && old_act[cs]) begin
            m_act[cs] = 0;
            m_score   = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [NS-1:0]    e_act;
   logic [2*NS-1:0]  e_lane;
   logic [YW*NS-1:0] e_y;

   always @(negedge Clk) begin
      if (cmp_en) begin
         for (int i = 0; i < NS; i++) begin
            e_act[i]           = m_act[i];
            e_lane[2*i +: 2]   = m_lane[i][1:0];
            e_y[YW*i +: YW]    = m_y[i][YW-1:0];
         end
         check("model_active",   bus.slot_active, e_act);
         check("model_lane",     bus.slot_lane,   e_lane);
         check("model_y",        bus.slot_y,      e_y);
         check("model_score",    bus.score_inc,   m_score);
         check("model_miss",     bus.miss,        m_miss);
         check("model_overflow", bus.overflow,    m_ovf);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
         bus.spawn_req   = '0;
         bus.frame_tick  = 1'b0;
         bus.catch_valid = 1'b0;
         bus.catch_slot  = '0;
         bus.clear       = 1'b0;
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step(1);
      Reset = 1'b0;
   endtask

   task automatic frame();
      bus.frame_tick = 1'b1;
      step(6);
   endtask

   initial begin
      Reset           = 1'b1;
      bus.clear       = 1'b0;
      bus.spawn_req   = '0;
      bus.frame_tick  = 1'b0;
      bus.catch_valid = 1'b0;
      bus.catch_slot  = '0;
      do_reset();
      cmp_en = 1'b1;

      // 1) reset state and single spawn latency
      check("rst_active",   bus.slot_active, 0);
      check("rst_lane",     bus.slot_lane,   0);
      check("rst_y",        bus.slot_y,      0);
      check("rst_score",    bus.score_inc,   0);
      check("rst_miss",     bus.miss,        0);
      check("rst_overflow", bus.overflow,    0);
      bus.spawn_req = 4'b0001;
      step(2);
      check("t1_not_before_t3", bus.slot_active, 4'b0000);
      step(1);
      check("t1_active", bus.slot_active, 4'b0001);
      check("t1_lane",   bus.slot_lane[1:0], 2'd0);
      check("t1_y",      bus.slot_y[9:0], 10'd0);
      check("t1_score",  bus.score_inc, 0);
      check("t1_miss",   bus.miss, 0);

      // 2) four lanes at once, one ALLOC each
      do_reset();
      bus.spawn_req = 4'b1111;
      step(3);
      check("t2_a1", bus.slot_active, 4'b0001);
      step(2);
      check("t2_a2", bus.slot_active, 4'b0011);
      step(2);
      check("t2_a3", bus.slot_active, 4'b0111);
      step(2);
      check("t2_a4",   bus.slot_active, 4'b1111);
      check("t2_lane", bus.slot_lane, 8'hE4);
      check("t2_ovf",  bus.overflow, 0);

      // 3) 240 frames on one slot: bottom reached on the last one
      do_reset();
      bus.spawn_req = 4'b0001;
      step(3);
      repeat (239) frame();
      check("t3_y478",  bus.slot_y[9:0], 10'd478);
      check("t3_alive", bus.slot_active, 4'b0001);
      bus.frame_tick = 1'b1;
      step(2);
      check("t3_miss",      bus.miss, 1);
      check("t3_freed",     bus.slot_active, 4'b0000);
      check("t3_y_kept",    bus.slot_y[9:0], 10'd478);
      step(1);
      check("t3_miss_pulse", bus.miss, 0);

      // 4) catch beats the fall step on the slot under update
      do_reset();
      bus.spawn_req = 4'b1111;
      step(9);
      repeat (239) frame();
      check("t4_all478", bus.slot_y, {4{10'd478}});
      bus.frame_tick = 1'b1;
      step(3);
      bus.catch_valid = 1'b1;
      bus.catch_slot  = 2'd2;
      step(1);
      check("t4_score",  bus.score_inc, 1);
      check("t4_nomiss", bus.miss, 0);
      check("t4_active", bus.slot_active, 4'b1000);
      step(1);
      check("t4_miss3",  bus.miss, 1);
      check("t4_empty",  bus.slot_active, 4'b0000);

      // 5) pool full: held request, overflow, retry after a catch
      do_reset();
      bus.spawn_req = 4'b1111;
      step(9);
      bus.spawn_req = 4'b0010;
      step(1);
      check("t5_no_ovf", bus.overflow, 0);
      step(2);
      check("t5_held", bus.slot_active, 4'b1111);
      bus.spawn_req = 4'b0010;
      step(1);
      check("t5_ovf", bus.overflow, 1);
      bus.catch_valid = 1'b1;
      bus.catch_slot  = 2'd3;
      step(1);
      check("t5_caught", bus.slot_active, 4'b0111);
      check("t5_score",  bus.score_inc, 1);
      step(2);
      check("t5_realloc", bus.slot_active, 4'b1111);
      check("t5_lane1",   bus.slot_lane[7:6], 2'd1);
      check("t5_ovf_hold", bus.overflow, 1);

      // 6) clear in the middle of UPDATE
      bus.spawn_req = 4'b0001;
      step(1);
      bus.frame_tick = 1'b1;
      step(2);
      bus.clear = 1'b1;
      step(1);
      check("t6_active", bus.slot_active, 4'b0000);
      check("t6_ovf",    bus.overflow, 0);
      check("t6_y",      bus.slot_y, 0);
      step(4);
      check("t6_pend_gone", bus.slot_active, 4'b0000);
      bus.catch_valid = 1'b1;
      bus.catch_slot  = 2'd1;
      step(1);
      check("t6_catch_empty", bus.score_inc, 0);
      bus.spawn_req = 4'b0110;
      step(3);
      check("t6_rr_first", bus.slot_lane[1:0], 2'd1);
      step(2);
      check("t6_rr_second", bus.slot_lane[3:2], 2'd2);

      // 7) frame tick during ALLOC is remembered
      do_reset();
      bus.spawn_req = 4'b0001;
      step(2);
      bus.frame_tick = 1'b1;
      step(1);
      check("t7_alloc", bus.slot_active, 4'b0001);
      step(2);
      check("t7_pending_tick", bus.slot_y[9:0], 10'd2);

      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
